sc_bi_window_b2s: RTL

Stochastic-to-binary back end for the 16-input bipolar stochastic MAC. It counts the ones in the scaled MAC output bitstream over a power-of-two window after a fixed pipeline-flush delay. It converts the count to a signed bipolar result, both full-precision and saturated to 8-bit Q1.7. It presents the result on a valid/ready handshake to the binary consumer.

---
 rtl/sc_b2s_pkg.sv | 10 +
 rtl/sc_b2s_sat.sv | 33 +++
 rtl/sc_bi_window_b2s.sv | 116 +++++++++++
 3 files changed

// File: rtl/sc_b2s_pkg.sv
// Shared types and Q1.7 limits for the stochastic-to-binary back ends.
package sc_b2s_pkg;

    typedef enum logic [1:0] {IDLE, SKIP, COUNT, HOLD} b2s_state_t;

    localparam int unsigned SAT_W   = 8;
    localparam int          SAT_MAX = 127;
    localparam int          SAT_MIN = -128;

endpackage

// File: rtl/sc_b2s_sat.sv
// Ones count to signed bipolar value, full precision and clamped Q1.7.
module sc_b2s_sat
    import sc_b2s_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 8
) (
    input  logic [WIN_LOG2:0]          n,
    output logic signed [WIN_LOG2+1:0] sum_c,
    output logic signed [SAT_W-1:0]    sat_c
);

    localparam int unsigned SW = WIN_LOG2 + 2;
    localparam int unsigned SH = WIN_LOG2 - 7;
    localparam int unsigned W  = 1 << WIN_LOG2;

    logic signed [SW-1:0] d;
    logic signed [SW-1:0] sh;

    // D = 2N - W wraps correctly in SW bits since |D| <= W; then scale and clamp.
    always_comb begin
        d     = SW'({n, 1'b0}) - SW'(W);
        sh    = d >>> SH;
        sum_c = d;
        if (sh > SW'(SAT_MAX)) begin
            sat_c = SAT_W'(SAT_MAX);
        end else if (sh < SW'(SAT_MIN)) begin
            sat_c = SAT_W'(SAT_MIN);
        end else begin
            sat_c = SAT_W'(sh);
        end
    end

endmodule

// File: rtl/sc_bi_window_b2s.sv
// Windowed ones counter turning the bipolar MAC bitstream into a binary result.
module sc_bi_window_b2s #(
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned SKIP     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iBit,
    input  logic                       iStart,
    input  logic                       iReady,
    output logic                       oBusy,
    output logic                       oValid,
    output logic signed [WIN_LOG2+1:0] oSum,
    output logic signed [7:0]          oSat
);

    import sc_b2s_pkg::b2s_state_t;

    localparam int unsigned W          = 1 << WIN_LOG2;
    localparam int unsigned NW         = WIN_LOG2 + 1;
    localparam int unsigned CW         = ((WIN_LOG2 > 4) ? WIN_LOG2 : 4) + 1;
    localparam int unsigned SKIP_LAST  = (SKIP > 0) ? SKIP - 1 : 0;
    localparam int unsigned COUNT_LAST = W - 1;
    localparam b2s_state_t  START_ST   = (SKIP > 0) ? sc_b2s_pkg::SKIP : sc_b2s_pkg::COUNT;

    b2s_state_t                 state, state_d;
    logic [CW-1:0]              cnt, cnt_d;
    logic [NW-1:0]              n, n_d, n_inc;
    logic                       load;
    logic signed [WIN_LOG2+1:0] sum_c;
    logic signed [7:0]          sat_c;

    // Final count includes the bit presented on the last COUNT cycle.
    assign n_inc = n + NW'(iBit);

    sc_b2s_sat #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_sat (
        .n     (n_inc),
        .sum_c (sum_c),
        .sat_c (sat_c)
    );

    // Next-state logic; one cycle counter serves both SKIP and COUNT.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        n_d     = n;
        load    = 1'b0;
        case (state)
            sc_b2s_pkg::IDLE: begin
                if (iStart) begin
                    state_d = START_ST;
                    cnt_d   = '0;
                    n_d     = '0;
                end
            end
            sc_b2s_pkg::SKIP: begin
                if (cnt == CW'(SKIP_LAST)) begin
                    state_d = sc_b2s_pkg::COUNT;
                    cnt_d   = '0;
                    n_d     = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            sc_b2s_pkg::COUNT: begin
                n_d = n_inc;
                if (cnt == CW'(COUNT_LAST)) begin
                    state_d = sc_b2s_pkg::HOLD;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            sc_b2s_pkg::HOLD: begin
                if (iReady) begin
                    if (iStart) begin
                        state_d = START_ST;
                        cnt_d   = '0;
                        n_d     = '0;
                    end else begin
                        state_d = sc_b2s_pkg::IDLE;
                    end
                end
            end
            default: begin
                state_d = sc_b2s_pkg::IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= sc_b2s_pkg::IDLE;
            cnt    <= '0;
            n      <= '0;
            oBusy  <= 1'b0;
            oValid <= 1'b0;
            oSum   <= '0;
            oSat   <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            n      <= n_d;
            oBusy  <= (state_d != sc_b2s_pkg::IDLE);
            oValid <= (state_d == sc_b2s_pkg::HOLD);
            if (load) begin
                oSum <= sum_c;
                oSat <= sat_c;
            end
        end
    end

endmodule
